// File: rtl/cia_pipe_sub_if.sv
// Valid/ready operand and result bundle for cia_pipe_sub.
// The ovf signal exists only when CIA_SUB_OVF_EN is defined.
interface cia_pipe_sub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef CIA_SUB_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, A, B, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf
   );

   modport slave (
      input  in_valid, A, B, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf
   );
`else
   modport master (
      output in_valid, A, B, bin, out_ready,
      input  in_ready, out_valid, diff, bout
   );

   modport slave (
      input  in_valid, A, B, bin, out_ready,
      output in_ready, out_valid, diff, bout
   );
`endif
endinterface

// File: rtl/cia_pipe_sub.sv
// Pipelined subtractor: diff = A + ~B + ~bin, one SLICE-bit ripple slice per stage.
// Define CIA_SUB_OVF_EN to add the signed-overflow output ovf.
module cia_pipe_sub #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input logic           clk,
   input logic           rst_n,
   cia_pipe_sub_if.slave bus
);
   localparam int N = WIDTH / SLICE;

   logic [N-1:0]     v;
   logic [N-1:0]     adv;
   logic [N-1:0]     brw;
   logic [N-1:0]     nxt_brw;
   logic [WIDTH-1:0] word_a  [N];
   logic [WIDTH-1:0] word_nb [N];
   logic [WIDTH-1:0] nxt_a   [N];
   logic [WIDTH-1:0] nxt_nb  [N];
   logic             accept;

   // A stage advances when it is valid and the stage ahead is empty or also advancing.
   always_comb begin
      logic [N-1:0] go;
      go        = '0;
      go[N-1]   = v[N-1] & bus.out_ready;
      for (int k = N - 2; k >= 0; k--) begin
         go[k] = v[k] & (~v[k+1] | go[k+1]);
      end
      adv = go;
   end

   assign bus.in_ready  = ~v[0] | adv[0];
   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.out_valid = v[N-1];
   assign bus.diff      = word_a[N-1];
   assign bus.bout      = brw[N-1];

   // word_a carries resolved result bits below the current slice and raw A above it;
   // word_nb carries raw ~B above the current slice. brw is the inverted carry out.
   always_comb begin
      logic [SLICE:0] sum;

      sum        = {1'b0, bus.A[SLICE-1:0]} + {1'b0, ~bus.B[SLICE-1:0]}
                 + {{SLICE{1'b0}}, ~bus.bin};
      nxt_a[0]   = bus.A;
      nxt_a[0][SLICE-1:0]  = sum[SLICE-1:0];
      nxt_nb[0]  = ~bus.B;
      nxt_nb[0][SLICE-1:0] = '0;
      nxt_brw    = '0;
      nxt_brw[0] = ~sum[SLICE];

      for (int k = 1; k < N; k++) begin
         sum      = {1'b0, word_a[k-1][k*SLICE +: SLICE]}
                  + {1'b0, word_nb[k-1][k*SLICE +: SLICE]}
                  + {{SLICE{1'b0}}, ~brw[k-1]};
         nxt_a[k] = word_a[k-1];
         nxt_a[k][k*SLICE +: SLICE]  = sum[SLICE-1:0];
         nxt_nb[k] = word_nb[k-1];
         nxt_nb[k][k*SLICE +: SLICE] = '0;
         nxt_brw[k] = ~sum[SLICE];
      end
   end

   // Each stage loads when its upstream advances; otherwise it holds and drops valid if drained.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v   <= '0;
         brw <= '0;
         for (int k = 0; k < N; k++) begin
            word_a[k]  <= '0;
            word_nb[k] <= '0;
         end
      end else begin
         if (accept) begin
            v[0]       <= 1'b1;
            word_a[0]  <= nxt_a[0];
            word_nb[0] <= nxt_nb[0];
            brw[0]     <= nxt_brw[0];
         end else if (adv[0]) begin
            v[0] <= 1'b0;
         end
         for (int k = 1; k < N; k++) begin
            if (adv[k-1]) begin
               v[k]       <= 1'b1;
               word_a[k]  <= nxt_a[k];
               word_nb[k] <= nxt_nb[k];
               brw[k]     <= nxt_brw[k];
            end else if (adv[k]) begin
               v[k] <= 1'b0;
            end
         end
      end
   end

`ifdef CIA_SUB_OVF_EN
   logic [N-1:0] sign_a;
   logic [N-1:0] sign_b;

   // Operand sign bits ride alongside the data since the top slice overwrites A's MSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sign_a <= '0;
         sign_b <= '0;
      end else begin
         if (accept) begin
            sign_a[0] <= bus.A[WIDTH-1];
            sign_b[0] <= bus.B[WIDTH-1];
         end
         for (int k = 1; k < N; k++) begin
            if (adv[k-1]) begin
               sign_a[k] <= sign_a[k-1];
               sign_b[k] <= sign_b[k-1];
            end
         end
      end
   end

   assign bus.ovf = (sign_a[N-1] ^ sign_b[N-1]) & (word_a[N-1][WIDTH-1] ^ sign_a[N-1]);
`endif

endmodule
